alarm_ctrl: RTL and testbench
=============================

Name: alarm_ctrl

Overview:
Alarm controller that decides when the alarm rings; it produces the alram_sound enable consumed by the piezo tune generator.
- Compares running clock time against the stored alarm time.
- Handles stop and snooze buttons.
- Auto-silences after a ring timeout.
- Sits between the timekeeping counter / alarm-setting registers and the sound generator.

Parameters:
RING_TIMEOUT, 60, seconds of continuous ringing before auto-stop
SNOOZE_SEC, 300, seconds spent silent in snooze before re-ringing
MAX_SNOOZE, 3, maximum snoozes per alarm event
TIMER_W, 9, width of the internal second counters (must hold max(RING_TIMEOUT, SNOOZE_SEC))

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  asynchronous, active-low reset
tick_1hz  input  1  one-clk-wide pulse once per second, synchronous to clk
alarm_en  input  1  alarm armed (level)
cur_hour  input  5  current hour, binary 0-23
cur_min  input  6  current minute, binary 0-59
cur_sec  input  6  current second, binary 0-59
alarm_hour  input  5  alarm hour, binary 0-23
alarm_min  input  6  alarm minute, binary 0-59
stop_btn  input  1  raw stop button, active-high, asynchronous
snooze_btn  input  1  raw snooze button, active-high, asynchronous
alram_sound  output  1  1 = sound generator enabled
state_out  output  2  current FSM state code
snooze_left  output  2  snoozes remaining

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on port reset.
- Reset values:
  - FSM = IDLE, so alram_sound=0 and state_out=2'b00.
  - snooze_left=MAX_SNOOZE.
  - ring_timer=0, snooze_timer=0.
  - match_prev=0, and all button sync flops=0.
- Buttons: each passes through 2-flop synchroniser plus rising-edge detect, giving a one-cycle pulse (stop_p, snooze_p). Latency from raw rise to pulse is 3 clk.
- Match:
  - match = alarm_en & (cur_hour==alarm_hour) & (cur_min==alarm_min) & (cur_sec==0).
  - trig = match & ~match_prev, registered each clk.
  - Exactly one trigger per alarm minute.
- States: IDLE=00, RINGING=01, SNOOZE=10; code 11 is illegal and recovers to IDLE.
- IDLE:
  - On trig: go to RINGING, ring_timer=0, snooze_left=MAX_SNOOZE.
- RINGING (alram_sound=1):
  - ring_timer increments on tick_1hz.
  - Priority is stop_p > snooze_p > timeout.
  - stop_p: go to IDLE.
  - snooze_p with snooze_left>0: go to SNOOZE, snooze_timer=SNOOZE_SEC, snooze_left decrements.
  - snooze_p with snooze_left==0: ignored, stays RINGING.
  - ring_timer==RING_TIMEOUT-1 and tick_1hz: go to IDLE (auto-stop).
- SNOOZE (alram_sound=0):
  - snooze_timer decrements on tick_1hz.
  - stop_p: go to IDLE.
  - snooze_timer==1 and tick_1hz: go to RINGING, ring_timer=0.
- Any state: alarm_en=0 forces IDLE on the next clk. Same-cycle precedence: alarm_en=0 > stop_p > others.
- trig in RINGING or SNOOZE is ignored.
- alram_sound is a registered decode of state, so it changes 1 clk after the state-transition cycle.
- Counters saturate and never wrap. Widths are fixed by TIMER_W.

Optional Feature:
Macro ALARM_SNOOZE_EN.
- Defined: snooze behaves as above.
- Undefined:
  - snooze_btn synchroniser is not built and snooze_btn is ignored.
  - SNOOZE state is unreachable.
  - snooze_left is held at 0.
  - RINGING exits only on stop, timeout or alarm_en=0.

Decomposition:
- Package alarm_pkg:
  - state encoding constants (IDLE/RINGING/SNOOZE).
  - HOUR_W=5, MIN_W=6, SEC_W=6.
  - default RING_TIMEOUT, SNOOZE_SEC and MAX_SNOOZE values.
- Sub-module btn_edge:
  - 2-flop sync plus rising-edge pulse, async active-low reset.
  - Instantiated once per button.

Test Plan:
- Alarm 07:30 enabled, time steps 07:29:59 -> 07:30:00 -> alram_sound=1 within 2 clk; stays 1 through 07:30:59 with a single trigger.
- Ringing, stop_btn pulse held 5 clk -> alram_sound=0 by clk 5 after rise, state_out=00; no re-ring at 07:30:01.
- Ringing, no buttons, 60 tick_1hz pulses -> auto-stop after the 60th tick, state_out=00.
- Ringing, snooze pressed -> state_out=10, snooze_left=2, sound off; 300 ticks later sound=1. Repeat to snooze_left=0; 4th snooze is ignored and stays ringing.
- stop_btn and snooze_btn rise in the same cycle while RINGING -> IDLE, snooze_left unchanged.
- Reset asserted mid-SNOOZE -> immediately state_out=00, alram_sound=0, snooze_left=3. alarm_en=0 during RINGING -> IDLE next clk.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared state encoding, field widths and default timing for the alarm controller.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RINGING = 2'b01,
        ST_SNOOZE  = 2'b10
    } state_e;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam int RING_TIMEOUT_DEF = 60;
    localparam int SNOOZE_SEC_DEF   = 300;
    localparam int MAX_SNOOZE_DEF   = 3;
    localparam int TIMER_W_DEF      = 9;

endpackage

// File: rtl/alarm_ctrl_btn_edge.sv
// Raw button to one-clock pulse: two-flop synchroniser, then a registered rising-edge detect.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;
    logic pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pulse_q <= s2_q & ~s3_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm ring/stop/snooze controller driving the piezo sound enable.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT = RING_TIMEOUT_DEF,
    parameter int SNOOZE_SEC   = SNOOZE_SEC_DEF,
    parameter int MAX_SNOOZE   = MAX_SNOOZE_DEF,
    parameter int TIMER_W      = TIMER_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic              alarm_en,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MIN_W-1:0]  alarm_min,
    input  logic              stop_btn,
    input  logic              snooze_btn,
    output logic              alram_sound,
    output logic [1:0]        state_out,
    output logic [1:0]        snooze_left
);

`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    localparam logic [1:0] LEFT_INIT =
        SNZ_EN ? 2'(MAX_SNOOZE) : 2'd0;
    localparam logic [TIMER_W-1:0] RING_LAST =
        TIMER_W'(RING_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SNZ_LOAD =
        TIMER_W'(SNOOZE_SEC);

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] ring_q, ring_d;
    logic [TIMER_W-1:0] snz_q, snz_d;
    logic [1:0]         left_q, left_d;
    logic               sound_q;
    logic               match_prev_q;
    logic               match;
    logic               trig;
    logic               stop_p;
    logic               snooze_p;

    btn_edge u_stop (
        .clk     (clk),
        .rst_n   (reset),
        .btn_i   (stop_btn),
        .pulse_o (stop_p)
    );

`ifdef ALARM_SNOOZE_EN
    btn_edge u_snooze (
        .clk     (clk),
        .rst_n   (reset),
        .btn_i   (snooze_btn),
        .pulse_o (snooze_p)
    );
`else
    logic unused_snooze_btn;
    assign unused_snooze_btn = snooze_btn;
    assign snooze_p          = 1'b0;
`endif

    // Edge on match gives one trigger per alarm minute.
    assign match = alarm_en
                 && (cur_hour == alarm_hour)
                 && (cur_min == alarm_min)
                 && (cur_sec == '0);
    assign trig  = match & ~match_prev_q;

    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        left_d  = left_q;
        if (!alarm_en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (trig) begin
                        state_d = ST_RINGING;
                        ring_d  = '0;
                        left_d  = LEFT_INIT;
                    end
                end
                ST_RINGING: begin
                    if (tick_1hz && ring_q != '1)
                        ring_d = ring_q + TIMER_W'(1);
                    if (stop_p) begin
                        state_d = ST_IDLE;
                    end else if (snooze_p && left_q != 2'd0) begin
                        state_d = ST_SNOOZE;
                        snz_d   = SNZ_LOAD;
                        left_d  = left_q - 2'd1;
                    end else if (tick_1hz && ring_q == RING_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SNOOZE: begin
                    if (tick_1hz && snz_q != '0)
                        snz_d = snz_q - TIMER_W'(1);
                    if (stop_p) begin
                        state_d = ST_IDLE;
                    end else if (tick_1hz && snz_q == TIMER_W'(1)) begin
                        state_d = ST_RINGING;
                        ring_d  = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ring_q       <= '0;
            snz_q        <= '0;
            left_q       <= LEFT_INIT;
            sound_q      <= 1'b0;
            match_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_q       <= ring_d;
            snz_q        <= snz_d;
            left_q       <= left_d;
            sound_q      <= (state_q == ST_RINGING);
            match_prev_q <= match;
        end
    end

    assign alram_sound = sound_q;
    assign state_out   = state_q;
    assign snooze_left = left_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with a per-cycle reference model.
module tb_alarm_ctrl;
    import alarm_pkg::*;

`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif
    localparam int RT    = 60;
    localparam int SS    = 300;
    localparam int LEFT0 = SNZ ? 3 : 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       alarm_en = 1'b0;
    logic [4:0] cur_hour = 5'd0;
    logic [5:0] cur_min = 6'd0;
    logic [5:0] cur_sec = 6'd0;
    logic [4:0] alarm_hour = 5'd7;
    logic [5:0] alarm_min = 6'd30;
    logic       stop_btn = 1'b0;
    logic       snooze_btn = 1'b0;
    logic       alram_sound;
    logic [1:0] state_out;
    logic [1:0] snooze_left;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_on = 1'b0;

    always #5 clk = ~clk;

    alarm_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .alarm_en    (alarm_en),
        .cur_hour    (cur_hour),
        .cur_min     (cur_min),
        .cur_sec     (cur_sec),
        .alarm_hour  (alarm_hour),
        .alarm_min   (alarm_min),
        .stop_btn    (stop_btn),
        .snooze_btn  (snooze_btn),
        .alram_sound (alram_sound),
        .state_out   (state_out),
        .snooze_left (snooze_left)
    );

    // Reference model: 0 idle, 1 ringing, 2 snoozing.
    int       m_state = 0;
    int       m_left = LEFT0;
    int       m_rung = 0;
    int       m_snz_left = 0;
    bit       m_sound = 1'b0;
    bit       m_prev = 1'b0;
    logic [3:0] sh = '0;
    logic [3:0] zh = '0;
    bit       match, trig, stop_ev, snz_ev;
    int       nxt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state    = 0;
            m_left     = LEFT0;
            m_rung     = 0;
            m_snz_left = 0;
            m_sound    = 1'b0;
            m_prev     = 1'b0;
            sh         = '0;
            zh         = '0;
        end else begin
            match = alarm_en && cur_hour == alarm_hour
                 && cur_min == alarm_min && cur_sec == 6'd0;
            trig    = match && !m_prev;
            m_prev  = match;
            stop_ev = sh[2] && !sh[3];
            snz_ev  = SNZ && zh[2] && !zh[3];
            sh      = {sh[2:0], stop_btn};
            zh      = {zh[2:0], snooze_btn};
            m_sound = (m_state == 1);
            nxt     = m_state;
            if (!alarm_en) begin
                nxt = 0;
            end else if (m_state == 0) begin
                if (trig) begin
                    nxt = 1; m_rung = 0; m_left = LEFT0;
                end
            end else if (m_state == 1) begin
                if (stop_ev) nxt = 0;
                else if (snz_ev && m_left > 0) begin
                    nxt = 2; m_snz_left = SS; m_left--;
                end else if (tick_1hz) begin
                    m_rung++;
                    if (m_rung == RT) nxt = 0;
                end
            end else begin
                if (stop_ev) nxt = 0;
                else if (tick_1hz) begin
                    m_snz_left--;
                    if (m_snz_left == 0) begin
                        nxt = 1; m_rung = 0;
                    end
                end
            end
            m_state = nxt;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_on) begin
            chk("cyc.state", int'(state_out), m_state);
            chk("cyc.sound", int'(alram_sound), int'(m_sound));
            chk("cyc.left", int'(snooze_left), m_left);
        end
    end

    task automatic lit(input string tag, input int st,
                       input int snd, input int left);
        chk({tag, ".state"}, int'(state_out), st);
        chk({tag, ".sound"}, int'(alram_sound), snd);
        chk({tag, ".left"}, int'(snooze_left), left);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hour = 5'(h);
        cur_min  = 6'(m);
        cur_sec  = 6'(s);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            step();
        end
    endtask

    task automatic tick_sec();
        if (cur_sec == 6'd59) begin
            cur_sec = 6'd0;
            if (cur_min == 6'd59) begin
                cur_min  = 6'd0;
                cur_hour = (cur_hour == 5'd23) ? 5'd0 : cur_hour + 5'd1;
            end else begin
                cur_min = cur_min + 6'd1;
            end
        end else begin
            cur_sec = cur_sec + 6'd1;
        end
        tick_n(1);
    endtask

    task automatic arm();
        set_time(7, 29, 59);
        step(2);
        tick_sec();
    endtask

    task automatic press(input bit stop, input bit snz);
        stop_btn   = stop;
        snooze_btn = snz;
        step(5);
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        step(1);
    endtask

    initial begin
        alarm_en = 1'b1;
        set_time(7, 29, 59);
        #1 reset = 1'b0;
        step(2);
        check_on = 1'b1;
        lit("reset", 0, 0, LEFT0);
        reset = 1'b1;
        step(3);
        lit("idle", 0, 0, LEFT0);

        // Trigger at 07:30:00, ring through the minute, then time out.
        tick_sec();
        lit("trig", 1, 1, LEFT0);
        repeat (59) tick_sec();
        lit("ring59", 1, 1, LEFT0);
        tick_sec();
        lit("timeout", 0, 0, LEFT0);

        // Stop button latency and no re-ring in the same minute.
        arm();
        stop_btn = 1'b1;
        step(3);
        lit("stop3", 1, 1, LEFT0);
        step(1);
        lit("stop4", 0, 1, LEFT0);
        step(1);
        lit("stop5", 0, 0, LEFT0);
        stop_btn = 1'b0;
        tick_sec();
        step(2);
        lit("norering", 0, 0, LEFT0);

`ifdef ALARM_SNOOZE_EN
        arm();
        press(1'b0, 1'b1);
        lit("snz1", 2, 0, 2);
        tick_n(SS - 1);
        lit("snz1_wait", 2, 0, 2);
        tick_n(1);
        lit("resume1", 1, 1, 2);
        press(1'b0, 1'b1);
        lit("snz2", 2, 0, 1);
        tick_n(SS);
        lit("resume2", 1, 1, 1);
        press(1'b0, 1'b1);
        lit("snz3", 2, 0, 0);
        tick_n(SS);
        lit("resume3", 1, 1, 0);
        press(1'b0, 1'b1);
        lit("snz4_ignored", 1, 1, 0);
        press(1'b1, 1'b0);
        lit("snz_stop", 0, 0, 0);
`else
        arm();
        press(1'b0, 1'b1);
        lit("snz_ignored", 1, 1, 0);
        press(1'b1, 1'b0);
        lit("snz_stop", 0, 0, 0);
`endif

        // Stop wins over snooze in the same cycle.
        arm();
        press(1'b1, 1'b1);
        lit("both", 0, 0, LEFT0);

        // Asynchronous reset in the middle of an alarm event.
        arm();
`ifdef ALARM_SNOOZE_EN
        press(1'b0, 1'b1);
        lit("pre_rst", 2, 0, 2);
`endif
        #2 reset = 1'b0;
        #1 lit("rst_async", 0, 0, LEFT0);
        set_time(7, 29, 59);
        step(2);
        reset = 1'b1;
        step(2);
        lit("after_rst", 0, 0, LEFT0);

        // Disarming while ringing.
        arm();
        alarm_en = 1'b0;
        step(1);
        lit("en_off1", 0, 1, LEFT0);
        step(1);
        lit("en_off2", 0, 0, LEFT0);
        set_time(7, 29, 59);
        step(2);
        tick_sec();
        step(2);
        lit("disarmed", 0, 0, LEFT0);
        set_time(8, 0, 0);
        alarm_en = 1'b1;
        step(3);
        lit("rearmed", 0, 0, LEFT0);

        check_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
